spi_shift_engine: RTL and testbench

SPI_SHIFT_ENGINE -- requirements
Module: spi_shift_engine

---
 rtl/spi_shift_engine_pkg.sv | 17 +
 rtl/spi_shift_engine.sv | 103 ++++++++++
 tb/tb_spi_shift_engine.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/spi_shift_engine_pkg.sv
// Shared SPI defines: character length, counter width, divider width and
// the shift engine state encoding.
package spi_shift_engine_pkg;

  // Longest character the shift engine handles, in bits.
  localparam int SPI_DATA_LEN    = 32;
  // Bit counters need one extra bit so they can hold the full length.
  localparam int SPI_CNT_W       = $clog2(SPI_DATA_LEN) + 1;
  // Width of the SPI clock divider in the clock generator.
  localparam int SPI_DIVIDER_LEN = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI shift engine: serialises tx_data onto mosi and assembles miso into
// rx_data, paced by edge pulses from an external SPI clock generator.
module spi_shift_engine
  import spi_shift_engine_pkg::*;
#(
  parameter int DATA_LEN = SPI_DATA_LEN,
  parameter int CNT_W    = $clog2(DATA_LEN) + 1
) (
  input  logic                clk_in,
  input  logic                rst,
  input  logic                start,
  input  logic [CNT_W-2:0]    char_len,
  input  logic                lsb_first,
  input  logic                tx_negedge,
  input  logic                rx_negedge,
  input  logic [DATA_LEN-1:0] tx_data,
  input  logic                pos_edge,
  input  logic                neg_edge,
  input  logic                miso,
  output logic                tip,
  output logic                last_clk,
  output logic                mosi,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                done
);

  localparam int IDX_W = $clog2(DATA_LEN);

  spi_state_e                state;
  logic                      lsb_q;
  logic                      tx_neg_q;
  logic                      rx_neg_q;
  logic [DATA_LEN-1:0]       tx_q;
  logic [CNT_W-1:0]          len_q;
  logic [CNT_W-1:0]          tx_cnt;
  logic [CNT_W-1:0]          rx_cnt;
  logic                      tx_edge;
  logic                      rx_edge;

  // Bit k of the character lives at word index k (LSB first) or N-1-k.
  function automatic logic [IDX_W-1:0] bit_idx(input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] idx;
    idx = lsb_q ? k : (len_q - CNT_W'(1) - k);
    return idx[IDX_W-1:0];
  endfunction

  assign tx_edge  = tx_neg_q ? neg_edge : pos_edge;
  assign rx_edge  = rx_neg_q ? neg_edge : pos_edge;
  assign tip      = (state == ST_XFER);
  // Tells the clock generator the final rx edge is the next one it makes.
  assign last_clk = tip && (rx_cnt == (len_q - CNT_W'(1)));

  // Transfer control, tx shift-out and rx shift-in; done is a registered pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state    <= ST_IDLE;
      lsb_q    <= 1'b0;
      tx_neg_q <= 1'b0;
      rx_neg_q <= 1'b0;
      tx_q     <= '0;
      len_q    <= '0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      mosi     <= 1'b0;
      rx_data  <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_XFER;
            lsb_q    <= lsb_first;
            tx_neg_q <= tx_negedge;
            rx_neg_q <= rx_negedge;
            tx_q     <= tx_data;
            len_q    <= (char_len == '0) ? CNT_W'(DATA_LEN) : {1'b0, char_len};
            tx_cnt   <= '0;
            rx_cnt   <= '0;
            rx_data  <= '0;
          end
        end
        ST_XFER: begin
          // tx and rx run independently so a shared edge moves both.
          if (tx_edge && (tx_cnt < len_q)) begin
            mosi   <= tx_q[bit_idx(tx_cnt)];
            tx_cnt <= tx_cnt + CNT_W'(1);
          end
          if (rx_edge && (rx_cnt < len_q)) begin
            rx_data[bit_idx(rx_cnt)] <= miso;
            rx_cnt                   <= rx_cnt + CNT_W'(1);
            if ((rx_cnt + CNT_W'(1)) == len_q) begin
              state <= ST_IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: the bench plays the clock
// generator, records every bit it expects on the wire and rebuilds words.
module tb_spi_shift_engine;

  localparam int DL = 32;
  localparam int CW = $clog2(DL) + 1;

  logic          clk_in = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-2:0] char_len;
  logic          lsb_first;
  logic          tx_negedge;
  logic          rx_negedge;
  logic [DL-1:0] tx_data;
  logic          pos_edge;
  logic          neg_edge;
  logic          miso;
  logic          tip;
  logic          last_clk;
  logic          mosi;
  logic [DL-1:0] rx_data;
  logic          done;

  int   checks = 0;
  int   errors = 0;
  logic exp_mosi = 1'b0;

  spi_shift_engine #(.DATA_LEN(DL)) dut (
    .clk_in     (clk_in),
    .rst        (rst),
    .start      (start),
    .char_len   (char_len),
    .lsb_first  (lsb_first),
    .tx_negedge (tx_negedge),
    .rx_negedge (rx_negedge),
    .tx_data    (tx_data),
    .pos_edge   (pos_edge),
    .neg_edge   (neg_edge),
    .miso       (miso),
    .tip        (tip),
    .last_clk   (last_clk),
    .mosi       (mosi),
    .rx_data    (rx_data),
    .done       (done)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edge pulses while idle must not disturb anything.
  task automatic idle_edges(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      pos_edge = 1'($urandom);
      neg_edge = 1'($urandom);
      miso     = 1'($urandom);
      @(negedge clk_in);
      chk("idle_tip", tip, 1'b0);
      chk("idle_done", done, 1'b0);
      chk("idle_mosi", mosi, exp_mosi);
      chk("idle_last_clk", last_clk, 1'b0);
    end
    pos_edge = 1'b0;
    neg_edge = 1'b0;
  endtask

  // One transfer. The bench acts as a clock generator emitting alternating
  // edges every div+1 cycles. poke_at>=0 pulses start and scrambles the mode
  // inputs once rx_seen reaches it; abort_at>0 resets after that many rx bits.
  task automatic run_xfer(input int len, input bit lsb, input bit txn, input bit rxn,
                          input logic [31:0] data, input int div, input bit loopback,
                          input bit first_pos, input bit noise, input bit b2b,
                          input int poke_at, input int abort_at, input bit chk_word);
    int          n;
    bit          txb[$];
    bit          rxb[$];
    int          tx_seen, rx_seen, cnt;
    bit          nxt_pos, pe, ne, fin, poked;
    logic [31:0] exp_rx, mask;
    logic [4:0]  len5;
    n = (len == 0) ? DL : len;
    for (int k = 0; k < n; k++) txb.push_back(data[lsb ? k : n - 1 - k]);
    if (!b2b) @(negedge clk_in);
    len5       = 5'(len);
    char_len   = len5;
    lsb_first  = lsb;
    tx_negedge = txn;
    rx_negedge = rxn;
    tx_data    = data;
    start      = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    chk("start_tip", tip, 1'b1);
    chk("start_rx_clr", rx_data, 32'h0);
    chk("start_done", done, 1'b0);
    tx_seen = 0; rx_seen = 0; cnt = 0; nxt_pos = first_pos; fin = 1'b0; poked = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      chk("last_clk", last_clk, (rx_seen == n - 1));
      chk("mosi", mosi, exp_mosi);
      if (abort_at > 0 && rx_seen == abort_at) begin
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        exp_mosi = 1'b0;
        chk("abort_tip", tip, 1'b0);
        chk("abort_rx", rx_data, 32'h0);
        chk("abort_mosi", mosi, 1'b0);
        chk("abort_done", done, 1'b0);
        return;
      end
      pe = 1'b0; ne = 1'b0;
      if (cnt == div) begin
        cnt = 0; pe = nxt_pos; ne = !nxt_pos; nxt_pos = !nxt_pos;
      end else cnt++;
      pos_edge = pe;
      neg_edge = ne;
      miso     = loopback ? mosi : 1'($urandom);
      if ((rxn ? ne : pe) && rx_seen < n) begin rxb.push_back(miso); rx_seen++; end
      if ((txn ? ne : pe) && tx_seen < n) begin exp_mosi = txb[tx_seen]; tx_seen++; end
      if ((noise && $urandom_range(0, 7) == 0) || (!poked && poke_at >= 0 && rx_seen >= poke_at)) begin
        poked      = 1'b1;
        start      = 1'b1;
        lsb_first  = 1'($urandom);
        tx_negedge = 1'($urandom);
        rx_negedge = 1'($urandom);
        char_len   = 5'($urandom);
        tx_data    = $urandom;
      end
      @(negedge clk_in);
      pos_edge = 1'b0;
      neg_edge = 1'b0;
      start    = 1'b0;
      fin = (rx_seen == n);
      chk("done", done, fin);
      chk("tip", tip, !fin);
      if (fin) break;
    end
    if (!fin) chk("timeout", 1'b0, 1'b1);
    exp_rx = '0;
    for (int k = 0; k < rxb.size(); k++) exp_rx[lsb ? k : n - 1 - k] = rxb[k];
    chk("rx_data", rx_data, exp_rx);
    chk("mosi_end", mosi, exp_mosi);
    if (chk_word) begin
      mask = (n == DL) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
      chk("rx_word", rx_data, data & mask);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; char_len = '0; lsb_first = 1'b0; tx_negedge = 1'b0;
    rx_negedge = 1'b0; tx_data = '0; pos_edge = 1'b0; neg_edge = 1'b0; miso = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_tip", tip, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_rx", rx_data, 32'h0);
    chk("rst_last_clk", last_clk, 1'b0);
    rst = 1'b0;
    idle_edges(3);

    // 8-bit MSB first, tx on neg, rx on pos, looped back.
    run_xfer(8, 0, 1, 0, 32'hA5, 1, 1, 0, 0, 0, -1, 0, 1);
    chk("a5_word", rx_data, 32'h0000_00A5);
    // 16-bit LSB first, looped back.
    run_xfer(16, 1, 1, 0, 32'h1234, 2, 1, 0, 0, 0, -1, 0, 1);
    chk("w1234_word", rx_data, 32'h0000_1234);
    // Full length via char_len=0 with an edge every cycle.
    run_xfer(0, 0, 1, 0, 32'hDEADBEEF, 0, 1, 0, 0, 0, -1, 0, 1);
    chk("dead_word", rx_data, 32'hDEAD_BEEF);
    idle_edges(4);
    // start pulsed mid-transfer at bit 3 is ignored.
    run_xfer(8, 0, 0, 1, 32'h3C, 1, 1, 1, 0, 0, 3, 0, 1);
    // Back-to-back start coincident with done.
    run_xfer(12, 1, 0, 0, 32'hABC, 0, 0, 1, 0, 1, -1, 0, 0);
    // Reset after bit 5 aborts, then a fresh transfer completes.
    run_xfer(8, 0, 1, 0, 32'h96, 0, 1, 0, 0, 0, -1, 5, 0);
    idle_edges(3);
    run_xfer(8, 0, 1, 0, 32'h69, 0, 1, 0, 0, 0, -1, 0, 1);

    // Randomised modes, lengths, dividers and mid-transfer noise.
    for (int t = 0; t < 30; t++) begin
      run_xfer($urandom_range(0, DL - 1), 1'($urandom), 1'($urandom), 1'($urandom),
               $urandom, $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'b1,
               1'($urandom), -1, 0, 0);
      if ($urandom_range(0, 2) == 0) idle_edges($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
